ilk_word_lock: RTL
==================

Name: ilk_word_lock

Overview:
Interlaken RX lane word-lock and de-inversion stage. Sits directly downstream of gearbox_20_67 and consumes its 67-bit dout/dout_valid stream. It checks the 2-bit sync header of each word and drives gearbox_20_67's slip_to_frame until word boundaries are found. After lock it strips the framing bits, undoes bit-66 inversion, and presents 64-bit words with a control flag to the descrambler/metaframe stage.

Parameters:
LOCK_GOOD, 64, consecutive good sync headers required in HUNT to declare lock.
WINDOW, 64, valid-word window length for loss-of-lock evaluation while LOCKED.
LOSS_BAD, 16, bad headers within one WINDOW that force loss of lock.
SLIP_WAIT, 4, valid words ignored after a slip pulse so the gearbox can realign.

Ports:
clk  in  1  lane clock, shared with gearbox_20_67
arst  in  1  reset; synchronous, active-high, sampled on rising clk
din  in  67  word from gearbox_20_67: [66]=inversion, [65:64]=sync header, [63:0]=payload
din_valid  in  1  din qualifier; words may arrive on any cycle, with gaps
slip_to_frame  out  1  single-cycle pulse to gearbox_20_67 requesting a one-bit slip
word_locked  out  1  high while in LOCKED
dout  out  64  de-inverted payload
dout_control  out  1  1 when the header was 2'b10 (control word), 0 for 2'b01 (data word)
dout_valid  out  1  dout/dout_control qualifier
hdr_err  out  1  single-cycle pulse for each bad-header word received while LOCKED

Behaviour:
- Good header: din[65:64] is 2'b01 or 2'b10. Bad header: 2'b00 or 2'b11. Evaluated only when din_valid=1. Cycles with din_valid=0 change no counter or state.
- Reset, synchronous: state=HUNT; good_cnt, wait_cnt, win_cnt and bad_cnt = 0. All outputs 0, including dout.
- HUNT:
  - Good header: good_cnt++. If this is good word number LOCK_GOOD, go to LOCKED; word_locked=1 from the next edge.
  - Bad header: slip_to_frame=1 for exactly one cycle, good_cnt=0, wait_cnt=0, go to SLIP_WAIT.
- SLIP_WAIT:
  - Each valid word increments wait_cnt; headers are ignored.
  - On valid word number SLIP_WAIT, go to HUNT with good_cnt=0.
  - slip_to_frame stays 0.
- LOCKED:
  - Each valid word increments win_cnt. A bad header also increments bad_cnt and pulses hdr_err.
  - If a bad header brings bad_cnt to LOSS_BAD: go to HUNT and clear all counters; word_locked=0 from the next edge; no slip is issued at this point.
  - Otherwise, on the valid word that completes the window (win_cnt reaches WINDOW), clear win_cnt and bad_cnt after counting that word. The window boundary is by valid words, not cycles.
- Datapath, registered, latency 1 clk:
  - dout_valid <= din_valid & (state==LOCKED) & good header. The state used is the state before this edge's update.
  - The word that completes lock is not output.
  - Bad-header words are never output; dout holds its last value.
  - dout <= din[66] ? ~din[63:0] : din[63:0], loaded only when dout_valid is set.
  - dout_control <= (din[65:64]==2'b10), loaded only when dout_valid is set.
- slip_to_frame, hdr_err and dout_valid are never high on consecutive cycles unless caused by consecutive valid words (hdr_err, dout_valid only).
- arst mid-operation: the next edge behaves as reset. Any in-flight dout_valid and slip pulse are dropped.
- Counter widths: $clog2(max parameter)+1. No wrap occurs within legal operation.

Test Plan:
- Reset, then 64 valid words {3'b010, 64'h1234167812345670} back-to-back -> word_locked=1 on the edge after word 64; no dout_valid for words 1-64. Word 65 gives dout=64'h1234167812345670, dout_control=1, dout_valid one clk later.
- HUNT with good words 1-9, then word 10 with header 2'b11 -> slip_to_frame high for one cycle only. The next 4 valid words are ignored even if bad (no further slip). 64 fresh good words are then needed for lock.
- LOCKED: inject 15 bad headers in one 64-word window -> 15 hdr_err pulses, word_locked stays 1. A 16th bad header in the same window -> word_locked=0 on the next edge and no dout_valid for that word.
- LOCKED: 8 bad headers in the last 8 words of a window plus 8 in the first words of the next window -> lock held, because counters clear at the boundary.
- De-inversion: locked, din={3'b110, 64'h00FF00FF00FF00FF} -> dout=64'hFF00FF00FF00FF00, dout_control=1. din={3'b001, 64'h0123456789ABCDEF} -> dout=64'h0123456789ABCDEF, dout_control=0.
- Gapped input with a 67-slot schedule (din_valid low on 47 of 67 cycles) -> lock after exactly 64 valid words. Assert arst while locked -> word_locked, dout_valid and dout all 0 on the next edge.

Source files
------------

// File: rtl/ilk_word_lock.sv
// Interlaken RX lane word lock: sync-header hunt, slip control,
// loss-of-lock windowing, framing strip and bit-66 de-inversion.
module ilk_word_lock #(
    parameter int LOCK_GOOD = 64,
    parameter int WINDOW    = 64,
    parameter int LOSS_BAD  = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [66:0] din,
    input  logic        din_valid,
    output logic        slip_to_frame,
    output logic        word_locked,
    output logic [63:0] dout,
    output logic        dout_control,
    output logic        dout_valid,
    output logic        hdr_err
);

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int MAXP = max4(LOCK_GOOD, WINDOW, LOSS_BAD, SLIP_WAIT);
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] GOOD_LAST = CW'(LOCK_GOOD - 1);
    localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
    localparam logic [CW-1:0] BAD_LAST  = CW'(LOSS_BAD - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SLIP_WAIT - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] good_cnt, good_cnt_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    logic [CW-1:0] win_cnt, win_cnt_n;
    logic [CW-1:0] bad_cnt, bad_cnt_n;
    logic          slip_n;
    logic          hdr_err_n;
    logic          out_v_n;
    logic          hdr_good;

    // 01 and 10 are the only legal sync headers
    assign hdr_good = din[65] ^ din[64];

    // State and counter registers
    always_ff @(posedge clk) begin
        if (arst) begin
            state    <= HUNT;
            good_cnt <= '0;
            wait_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_cnt_n;
            wait_cnt <= wait_cnt_n;
            win_cnt  <= win_cnt_n;
            bad_cnt  <= bad_cnt_n;
        end
    end

    // Next-state, counter updates and pulse requests; idle cycles hold everything
    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        wait_cnt_n = wait_cnt;
        win_cnt_n  = win_cnt;
        bad_cnt_n  = bad_cnt;
        slip_n     = 1'b0;
        hdr_err_n  = 1'b0;
        out_v_n    = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (hdr_good) begin
                        if (good_cnt == GOOD_LAST) begin
                            state_n    = LOCKED;
                            good_cnt_n = '0;
                            win_cnt_n  = '0;
                            bad_cnt_n  = '0;
                        end else begin
                            good_cnt_n = good_cnt + ONE;
                        end
                    end else begin
                        slip_n     = 1'b1;
                        good_cnt_n = '0;
                        wait_cnt_n = '0;
                        state_n    = SLIP_HOLD;
                    end
                end
                SLIP_HOLD: begin
                    // Headers are meaningless while the gearbox realigns
                    if (wait_cnt == WAIT_LAST) begin
                        state_n    = HUNT;
                        good_cnt_n = '0;
                        wait_cnt_n = '0;
                    end else begin
                        wait_cnt_n = wait_cnt + ONE;
                    end
                end
                LOCKED: begin
                    out_v_n = hdr_good;
                    if (!hdr_good) begin
                        hdr_err_n = 1'b1;
                    end
                    if (!hdr_good && bad_cnt == BAD_LAST) begin
                        // Loss of lock: re-hunt from scratch without slipping
                        state_n    = HUNT;
                        good_cnt_n = '0;
                        wait_cnt_n = '0;
                        win_cnt_n  = '0;
                        bad_cnt_n  = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt_n = '0;
                        bad_cnt_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + ONE;
                        if (!hdr_good) begin
                            bad_cnt_n = bad_cnt + ONE;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    // Registered outputs; dout/dout_control only load on accepted data words
    always_ff @(posedge clk) begin
        if (arst) begin
            slip_to_frame <= 1'b0;
            hdr_err       <= 1'b0;
            word_locked   <= 1'b0;
            dout_valid    <= 1'b0;
            dout          <= '0;
            dout_control  <= 1'b0;
        end else begin
            slip_to_frame <= slip_n;
            hdr_err       <= hdr_err_n;
            word_locked   <= (state_n == LOCKED);
            dout_valid    <= out_v_n;
            if (out_v_n) begin
                dout         <= din[66] ? ~din[63:0] : din[63:0];
                dout_control <= (din[65:64] == 2'b10);
            end
        end
    end

endmodule
